// File: rtl/clk_ratio_meter.sv
// Measures period and high time of a synchronous divided clock in source cycles; flags lock and stalls.
// Results are registered one cycle after the capturing edge; no backpressure, o_valid is a single-cycle pulse.
module clk_ratio_meter #(
   parameter int CNT_W      = 8,
   parameter int STABLE_CNT = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_div_clk,
   output logic [CNT_W-1:0] o_period,
   output logic [CNT_W-1:0] o_high,
   output logic             o_valid,
   output logic             o_locked,
   output logic             o_timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [3:0]       STAB_MAX = 4'(STABLE_CNT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             s_q;
   logic             rise, fall, sat;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_d, high_d;
   logic [3:0]       stab_q, stab_d;
   logic             valid_d, locked_d, timeout_d;

   assign rise = i_div_clk & ~s_q;
   assign fall = ~i_div_clk & s_q;
   assign sat  = (cnt_q == CNT_MAX);

   always_comb begin
      state_d   = state_q;
      cnt_d     = rise ? CNT_ONE : (sat ? cnt_q : cnt_q + CNT_ONE);
      period_d  = o_period;
      high_d    = o_high;
      valid_d   = 1'b0;
      locked_d  = o_locked;
      timeout_d = rise ? 1'b0 : o_timeout;
      stab_d    = stab_q;

      case (state_q)
         IDLE: begin
            if (rise) state_d = HIGH;
         end
         HIGH: begin
            if (fall) begin
               high_d  = cnt_q;
               state_d = LOW;
            end
         end
         LOW: begin
            if (rise) begin
               // o_period doubles as the history of the previous capture
               if (cnt_q == o_period)
                  stab_d = (stab_q >= STAB_MAX) ? STAB_MAX : stab_q + 4'd1;
               else
                  stab_d = 4'd1;
               period_d = cnt_q;
               valid_d  = 1'b1;
               locked_d = (stab_d >= STAB_MAX);
               state_d  = HIGH;
            end
         end
         default: state_d = IDLE;
      endcase

      // A rise on the saturating edge still counts as a valid edge
      if (sat && !rise) begin
         timeout_d = 1'b1;
         locked_d  = 1'b0;
         stab_d    = 4'd0;
         state_d   = IDLE;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         s_q       <= 1'b0;
         cnt_q     <= '0;
         stab_q    <= 4'd0;
         o_period  <= '0;
         o_high    <= '0;
         o_valid   <= 1'b0;
         o_locked  <= 1'b0;
         o_timeout <= 1'b0;
      end else begin
         state_q   <= state_d;
         s_q       <= i_div_clk;
         cnt_q     <= cnt_d;
         stab_q    <= stab_d;
         o_period  <= period_d;
         o_high    <= high_d;
         o_valid   <= valid_d;
         o_locked  <= locked_d;
         o_timeout <= timeout_d;
      end
   end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Bench for clk_ratio_meter: directed ratio/lock/timeout/reset scenarios plus random duty patterns
// checked cycle by cycle against an elapsed-time reference model.
module tb_clk_ratio_meter;

   localparam int MAXC = 255;
   localparam int STAB = 4;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_div_clk = 1'b0;
   logic [7:0] o_period, o_high;
   logic       o_valid, o_locked, o_timeout;

   int vecs = 0;
   int errs = 0;
   int cyc = 0;
   int last_rise_cyc = 0;
   int nrise = 0;
   logic prev_drv = 1'b0;

   clk_ratio_meter #(.CNT_W(8), .STABLE_CNT(STAB)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_div_clk(i_div_clk),
      .o_period(o_period), .o_high(o_high), .o_valid(o_valid),
      .o_locked(o_locked), .o_timeout(o_timeout)
   );

   always #5 i_clk = ~i_clk;

   // Reference model: measures everything as elapsed edges since the last rise.
   int         m_n, m_last_rise, m_phase, m_stab, m_prev_per, m_el;
   logic       m_prev_lvl, m_rise, m_fall;
   logic [7:0] m_period, m_high;
   logic       m_valid, m_locked, m_timeout;

   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         m_n = 0; m_last_rise = 0; m_phase = 0; m_stab = 0; m_prev_per = 0;
         m_prev_lvl = 1'b0; m_period = 8'd0; m_high = 8'd0;
         m_valid = 1'b0; m_locked = 1'b0; m_timeout = 1'b0;
      end else begin
         m_rise = i_div_clk && !m_prev_lvl;
         m_fall = !i_div_clk && m_prev_lvl;
         m_el = m_n - m_last_rise;
         if (m_el > MAXC) m_el = MAXC;
         m_valid = 1'b0;
         if (m_rise) m_timeout = 1'b0;
         if (m_phase == 2 && m_rise) begin
            m_stab = (m_el == m_prev_per) ? ((m_stab + 1 > STAB) ? STAB : m_stab + 1) : 1;
            m_prev_per = m_el;
            m_period = 8'(m_el);
            m_valid = 1'b1;
            m_locked = (m_stab >= STAB);
            m_phase = 1;
         end else if (m_phase == 1 && m_fall) begin
            m_high = 8'(m_el);
            m_phase = 2;
         end else if (m_phase == 0 && m_rise) begin
            m_phase = 1;
         end
         if (!m_rise && m_el >= MAXC) begin
            m_timeout = 1'b1; m_locked = 1'b0; m_stab = 0; m_phase = 0;
         end
         if (m_rise) m_last_rise = m_n;
         m_prev_lvl = i_div_clk;
         m_n = m_n + 1;
      end
   end

   task automatic drive(input logic lvl);
      i_div_clk = lvl;
      if (lvl && !prev_drv) begin
         last_rise_cyc = cyc;
         nrise++;
      end
      prev_drv = lvl;
      @(posedge i_clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset(input logic lvl);
      @(negedge i_clk);
      i_rst = 1'b1;
      i_div_clk = lvl;
      repeat (10) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      cyc = 0; nrise = 0; prev_drv = 1'b0; last_rise_cyc = 0;
   endtask

   task automatic test_reset;
      do_reset(1'b0);
      vecs++;
      if ({o_period, o_high, o_valid, o_locked, o_timeout} !== 19'd0) begin
         errs++;
         $display("FAIL reset_state: got %h want 0", {o_period, o_high, o_valid, o_locked, o_timeout});
      end
   endtask

   task automatic test_ratio9;
      int nv = 0;
      for (int p = 0; p < 6; p++) begin
         for (int i = 0; i < 9; i++) begin
            drive(i < 4);
            vecs++;
            if ({o_period, o_high, o_valid, o_locked, o_timeout} !== {m_period, m_high, m_valid, m_locked, m_timeout}) begin
               errs++;
               $display("FAIL ratio9_model cyc %0d: got %h want %h", cyc,
                        {o_period, o_high, o_valid, o_locked, o_timeout}, {m_period, m_high, m_valid, m_locked, m_timeout});
            end
            if (o_valid) begin
               nv++;
               vecs++;
               if (nrise < 2 || o_period !== 8'd9 || o_high !== 8'd4) begin
                  errs++;
                  $display("FAIL ratio9_capture: rise %0d period %0d high %0d want rise>=2 period 9 high 4", nrise, o_period, o_high);
               end
            end
            vecs++;
            if (o_locked !== (nv >= STAB)) begin
               errs++;
               $display("FAIL ratio9_lock: got %b want %b (valids %0d)", o_locked, nv >= STAB, nv);
            end
         end
      end
      vecs++;
      if (nv != 5) begin
         errs++;
         $display("FAIL ratio9_count: got %0d valids want 5", nv);
      end
   endtask

   task automatic test_ratio_switch;
      int nv6 = 0;
      for (int p = 0; p < 6; p++) begin
         for (int i = 0; i < 6; i++) begin
            drive(i < 3);
            vecs++;
            if ({o_period, o_high, o_valid, o_locked, o_timeout} !== {m_period, m_high, m_valid, m_locked, m_timeout}) begin
               errs++;
               $display("FAIL switch_model cyc %0d: got %h want %h", cyc,
                        {o_period, o_high, o_valid, o_locked, o_timeout}, {m_period, m_high, m_valid, m_locked, m_timeout});
            end
            if (o_valid) begin
               vecs++;
               if (o_period == 8'd6) begin
                  nv6++;
                  if (o_high !== 8'd3 || o_locked !== (nv6 >= STAB)) begin
                     errs++;
                     $display("FAIL switch_p6: high %0d locked %b want high 3 locked %b", o_high, o_locked, nv6 >= STAB);
                  end
               end else if (o_period !== 8'd9 || o_high !== 8'd4 || o_locked !== 1'b1) begin
                  errs++;
                  $display("FAIL switch_p9: period %0d high %0d locked %b want 9/4/1", o_period, o_high, o_locked);
               end
            end
         end
      end
      vecs++;
      if (nv6 != 5) begin
         errs++;
         $display("FAIL switch_count: got %0d valids of 6 want 5", nv6);
      end
   endtask

   task automatic test_timeout;
      bit seen = 0;
      for (int i = 0; i < 300; i++) begin
         drive(1'b0);
         vecs++;
         if ({o_period, o_high, o_valid, o_locked, o_timeout} !== {m_period, m_high, m_valid, m_locked, m_timeout}) begin
            errs++;
            $display("FAIL timeout_model cyc %0d: got %h want %h", cyc,
                     {o_period, o_high, o_valid, o_locked, o_timeout}, {m_period, m_high, m_valid, m_locked, m_timeout});
         end
         if (o_timeout && !seen) begin
            seen = 1;
            vecs++;
            if ((cyc - 1) - last_rise_cyc != MAXC || o_locked !== 1'b0) begin
               errs++;
               $display("FAIL timeout_delay: got %0d cycles locked %b want 255 locked 0", (cyc - 1) - last_rise_cyc, o_locked);
            end
         end
      end
      vecs++;
      if (!seen) begin
         errs++;
         $display("FAIL timeout_seen: got 0 want 1");
      end
      drive(1'b1);
      vecs++;
      if (o_timeout !== 1'b0 || o_valid !== 1'b0) begin
         errs++;
         $display("FAIL timeout_clear: timeout %b valid %b want 0 0", o_timeout, o_valid);
      end
      drive(1'b0);
      drive(1'b1);
      vecs++;
      if (o_valid !== 1'b1 || o_period !== 8'd2 || o_high !== 8'd1) begin
         errs++;
         $display("FAIL timeout_restart: valid %b period %0d high %0d want 1/2/1", o_valid, o_period, o_high);
      end
   endtask

   task automatic test_toggle;
      int nv = 0;
      do_reset(1'b0);
      for (int i = 0; i < 24; i++) begin
         drive(i[0] == 1'b0);
         if (o_valid) begin
            nv++;
            vecs++;
            if (o_period !== 8'd2 || o_high !== 8'd1) begin
               errs++;
               $display("FAIL toggle_capture: period %0d high %0d want 2/1", o_period, o_high);
            end
         end
         vecs++;
         if (o_locked !== (nv >= STAB) || o_timeout !== 1'b0) begin
            errs++;
            $display("FAIL toggle_flags: locked %b timeout %b want %b 0", o_locked, o_timeout, nv >= STAB);
         end
      end
      vecs++;
      if (nv != 11) begin
         errs++;
         $display("FAIL toggle_count: got %0d valids want 11", nv);
      end
   endtask

   task automatic test_async_reset;
      int nv = 0;
      for (int p = 0; p < 3; p++)
         for (int i = 0; i < 5; i++) drive(i < 2);
      drive(1'b1);
      #1 i_rst = 1'b1;
      #1;
      vecs++;
      if ({o_period, o_high, o_valid, o_locked, o_timeout} !== 19'd0) begin
         errs++;
         $display("FAIL async_reset: got %h want 0", {o_period, o_high, o_valid, o_locked, o_timeout});
      end
      #1 i_rst = 1'b0;
      cyc = 0; nrise = 0; prev_drv = 1'b0; last_rise_cyc = 0;
      drive(1'b0);
      drive(1'b0);
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 5; i++) begin
            drive(i < 2);
            vecs++;
            if ({o_period, o_high, o_valid, o_locked, o_timeout} !== {m_period, m_high, m_valid, m_locked, m_timeout}) begin
               errs++;
               $display("FAIL async_model cyc %0d: got %h want %h", cyc,
                        {o_period, o_high, o_valid, o_locked, o_timeout}, {m_period, m_high, m_valid, m_locked, m_timeout});
            end
            if (o_valid) begin
               nv++;
               vecs++;
               if (nrise < 2 || o_period !== 8'd5 || o_high !== 8'd2) begin
                  errs++;
                  $display("FAIL async_capture: rise %0d period %0d high %0d want rise>=2 5/2", nrise, o_period, o_high);
               end
            end
         end
      end
      vecs++;
      if (nv != 3) begin
         errs++;
         $display("FAIL async_count: got %0d valids want 3", nv);
      end
   endtask

   task automatic test_tied_high;
      bit seen = 0;
      bit any_valid = 0;
      do_reset(1'b1);
      for (int i = 0; i < 300; i++) begin
         drive(1'b1);
         if (o_valid) any_valid = 1;
         if (o_timeout && !seen) begin
            seen = 1;
            vecs++;
            if ((cyc - 1) - last_rise_cyc != MAXC) begin
               errs++;
               $display("FAIL tied_delay: got %0d cycles want 255", (cyc - 1) - last_rise_cyc);
            end
         end
      end
      vecs++;
      if (any_valid || !seen) begin
         errs++;
         $display("FAIL tied_high: valid_seen %b timeout_seen %b want 0 1", any_valid, seen);
      end
   endtask

   task automatic test_random;
      int h, l, sel, reps;
      do_reset(1'b0);
      for (int s = 0; s < 50; s++) begin
         h = $urandom_range(1, 10);
         l = $urandom_range(1, 10);
         sel = $urandom_range(0, 15);
         reps = $urandom_range(1, 6);
         if (sel == 0) begin l = 260; reps = 1; end
         if (sel == 1) begin l = MAXC - h; reps = 2; end
         for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < h + l; i++) begin
               drive(i < h);
               vecs++;
               if ({o_period, o_high, o_valid, o_locked, o_timeout} !== {m_period, m_high, m_valid, m_locked, m_timeout}) begin
                  errs++;
                  $display("FAIL random_model seg %0d cyc %0d: got %h want %h", s, cyc,
                           {o_period, o_high, o_valid, o_locked, o_timeout}, {m_period, m_high, m_valid, m_locked, m_timeout});
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_ratio9();
      test_ratio_switch();
      test_timeout();
      test_toggle();
      test_async_reset();
      test_tied_high();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
